flash_reader: RTL and testbench
===============================

# flash_reader

Upstream fetch stage for the Lab 2 audio path. It reads 32-bit sample words from the on-board flash over the Avalon-MM read interface and delivers each word to `audio_control` through that block's `data_in` input. It walks the flash address space forward or backward with wrap-around. It issues one read per request from the audio stage and honours `play_audio` and `forward` as the shared control inputs.

## Interface
- `ADDR_WIDTH`, default 23: flash word-address width.
- `MAX_ADDR`, default 23'h7FFFF: last valid word address (the wrap point).

- `clk`  in  1: system clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `play_audio`  in  1: 1 = new reads may be issued; 0 = no new reads (a read already in flight still completes).
- `forward`  in  1: 1 = step the address +1 after each word; 0 = step it −1.
- `restart`  in  1: pulse; reloads the address to 0 (`forward`=1) or `MAX_ADDR` (`forward`=0).
- `next_word`  in  1: pulse from the audio stage requesting the next word.
- `flash_mem_read`  out  1: Avalon read strobe.
- `flash_mem_address`  out  ADDR_WIDTH: Avalon word address.
- `flash_mem_byteenable`  out  4: constant 4'hF.
- `flash_mem_waitrequest`  in  1: slave stall.
- `flash_mem_readdata`  in  32: read data.
- `flash_mem_readdatavalid`  in  1: read data qualifier.
- `data_out`  out  32: last fetched word; drives `audio_control.data_in`.
- `data_valid`  out  1: one-cycle pulse when `data_out` updates.
- `busy`  out  1: high in any state except IDLE.

## Operation
- State machine states: IDLE, ISSUE, WAIT_DATA, LATCH.
- IDLE:
  - Go to ISSUE when `play_audio`=1 and (`next_word`=1 or `pending`=1).
  - Otherwise stay in IDLE.
- ISSUE:
  - `flash_mem_read`=1, with `flash_mem_address` held stable.
  - Go to WAIT_DATA in the first cycle `flash_mem_waitrequest`=0.
  - Stay in ISSUE while `flash_mem_waitrequest`=1.
- WAIT_DATA:
  - `flash_mem_read`=0.
  - On `flash_mem_readdatavalid`=1: capture `flash_mem_readdata` into `data_out` and go to LATCH.
  - `flash_mem_readdatavalid` is ignored in every other state.
- LATCH:
  - `data_valid`=1.
  - Update the address at the end of this cycle: restart reload if `restart_pend`=1, else step according to `forward` as sampled in this cycle.
  - Go to ISSUE if `play_audio`=1 and (`pending` or `next_word`); else go to IDLE.
- Address step rules (unsigned):
  - forward at `MAX_ADDR` → 0.
  - backward at 0 → `MAX_ADDR`.
  - Otherwise ±1.
- `pending`: one-deep request flag.
  - Set by `next_word`=1 in ISSUE or WAIT_DATA.
  - Cleared on entry to ISSUE.
  - Extra requests while already set are dropped.
- `restart`:
  - In IDLE: reload the address on the next edge.
  - In ISSUE, WAIT_DATA or LATCH: set `restart_pend`. The in-flight word is still delivered. The reload is applied in LATCH instead of the step, and `restart_pend` is then cleared.
  - `restart` in LATCH itself also counts as a restart.
- `play_audio`=0:
  - A request in IDLE is ignored and not remembered.
  - `pending` set during a transaction is retained until `play_audio` returns to 1.
- `forward` changes take effect on the next address step only; they never alter an in-flight address.

## Timing
- Reset values:
  - state IDLE
  - `flash_mem_address`=0
  - `flash_mem_read`=0
  - `data_out`=32'h0
  - `data_valid`=0
  - `busy`=0
  - `pending`=0
  - `restart_pend`=0
- Reset mid-transaction: abandon it immediately. No `data_valid` is produced and late `readdatavalid` is ignored, because the block is in IDLE.
- All outputs are registered or decoded from state; no combinational path from any input to any output.
- Minimum latency, with `waitrequest`=0 and `readdatavalid` one cycle after accept:
  - cycle 0: `next_word` sampled in IDLE.
  - cycle 1: ISSUE, read accepted.
  - cycle 2: WAIT_DATA, data captured.
  - cycle 3: LATCH, `data_valid`=1 and new `data_out` visible.
  - cycle 4: new address visible.
- Each `waitrequest` cycle or `readdatavalid` delay cycle adds one cycle of latency.
- Back-to-back throughput is one word per 3 cycles (LATCH→ISSUE direct).

## Test plan
- Reset, then `next_word` pulse with `forward`=1 and readdata 32'h12345678 → read at address 0; `data_valid` pulse in cycle 3 with `data_out`=32'h12345678; address becomes 1.
- `waitrequest` held high 3 cycles in ISSUE → `flash_mem_read` and address stable throughout; `data_valid` arrives 3 cycles later than the minimum.
- Address at `MAX_ADDR`, `forward`=1, one word fetched → address becomes 0. Then `forward`=0 at address 0, one word fetched → address becomes `MAX_ADDR`.
- `next_word` pulsed twice during WAIT_DATA → exactly one extra read, issued directly from LATCH; address advances by 2 in total.
- `restart` during WAIT_DATA at address 0x100, `forward`=1 → the word from 0x100 is still delivered; the address then becomes 0, not 0x101.
- `play_audio`=0 with `next_word` pulsed in IDLE → no read and `busy` stays 0. Separately, `reset` asserted in WAIT_DATA → IDLE with all outputs at reset values, and no `data_valid` even if `readdatavalid` follows.

Source files
------------

// File: rtl/flash_reader.sv
// ---------------------------------------------------------------------------
// flash_reader
//
// Fetch stage of the Lab 2 audio path. Reads 32-bit sample words from the
// on-board flash over an Avalon-MM read master and hands each word to
// audio_control (data_in). The word address walks forward or backward through
// 0..MAX_ADDR with wrap-around, one read per request from the audio stage.
//
// Parameters
//   ADDR_WIDTH : flash word-address width
//   MAX_ADDR   : last valid word address (wrap point)
//
// Ports
//   clk                     : system clock, rising edge
//   reset                   : synchronous, active-high
//   play_audio              : 1 = new reads may be issued
//   forward                 : 1 = address +1 per word, 0 = address -1
//   restart                 : pulse, reload address to 0 (fwd) / MAX_ADDR (bwd)
//   next_word               : pulse, audio stage requests the next word
//   flash_mem_read          : Avalon read strobe
//   flash_mem_address       : Avalon word address
//   flash_mem_byteenable    : always 4'hF
//   flash_mem_waitrequest   : Avalon slave stall
//   flash_mem_readdata      : Avalon read data
//   flash_mem_readdatavalid : Avalon read data qualifier
//   data_out                : last fetched word
//   data_valid              : one-cycle pulse when data_out updates
//   busy                    : high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module flash_reader #(
    parameter int                    ADDR_WIDTH = 23,
    parameter logic [ADDR_WIDTH-1:0] MAX_ADDR   = ADDR_WIDTH'('h7FFFF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_audio,
    input  logic                  forward,
    input  logic                  restart,
    input  logic                  next_word,
    output logic                  flash_mem_read,
    output logic [ADDR_WIDTH-1:0] flash_mem_address,
    output logic [3:0]            flash_mem_byteenable,
    input  logic                  flash_mem_waitrequest,
    input  logic [31:0]           flash_mem_readdata,
    input  logic                  flash_mem_readdatavalid,
    output logic [31:0]           data_out,
    output logic                  data_valid,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        LATCH     = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

    state_t state;
    logic   pending;       // one request remembered while a word is in flight
    logic   restart_pend;  // restart seen mid-transaction, applied in LATCH

    // Next address for one step in the requested direction, wrapping at both
    // ends of the 0..MAX_ADDR window.
    function automatic logic [ADDR_WIDTH-1:0] step_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  fwd
    );
        logic [ADDR_WIDTH-1:0] nxt;
        if (fwd) begin
            nxt = (addr == MAX_ADDR) ? ADDR_ZERO : addr + ADDR_ONE;
        end else begin
            nxt = (addr == ADDR_ZERO) ? MAX_ADDR : addr - ADDR_ONE;
        end
        return nxt;
    endfunction

    // Start point of a playback pass: bottom of flash when playing forward,
    // top of flash when playing backward.
    function automatic logic [ADDR_WIDTH-1:0] reload_addr(input logic fwd);
        return fwd ? ADDR_ZERO : MAX_ADDR;
    endfunction

    assign flash_mem_byteenable = 4'hF;

    // Single FSM process. flash_mem_read, data_valid and busy are registered
    // together with the state so they always agree with it and no input has
    // a combinational path to an output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            flash_mem_address <= '0;
            flash_mem_read    <= 1'b0;
            data_out          <= 32'h0;
            data_valid        <= 1'b0;
            busy              <= 1'b0;
            pending           <= 1'b0;
            restart_pend      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A reload here is visible before the read strobe rises,
                    // so a simultaneous request reads from the reloaded address.
                    if (restart) begin
                        flash_mem_address <= reload_addr(forward);
                    end
                    // With play_audio low a fresh request is dropped, but a
                    // request carried in 'pending' waits for play to return.
                    if (play_audio && (next_word || pending)) begin
                        state          <= ISSUE;
                        flash_mem_read <= 1'b1;
                        busy           <= 1'b1;
                        pending        <= 1'b0;
                    end
                end

                ISSUE: begin
                    if (restart) begin
                        restart_pend <= 1'b1;
                    end
                    if (next_word) begin
                        pending <= 1'b1;
                    end
                    // Address and strobe stay put until the slave accepts.
                    if (!flash_mem_waitrequest) begin
                        state          <= WAIT_DATA;
                        flash_mem_read <= 1'b0;
                    end
                end

                WAIT_DATA: begin
                    if (restart) begin
                        restart_pend <= 1'b1;
                    end
                    if (next_word) begin
                        pending <= 1'b1;
                    end
                    if (flash_mem_readdatavalid) begin
                        state      <= LATCH;
                        data_out   <= flash_mem_readdata;
                        data_valid <= 1'b1;
                    end
                end

                LATCH: begin
                    data_valid <= 1'b0;
                    // A restart seen anywhere during this transaction replaces
                    // the normal step; the delivered word is unaffected.
                    if (restart || restart_pend) begin
                        flash_mem_address <= reload_addr(forward);
                    end else begin
                        flash_mem_address <= step_addr(flash_mem_address, forward);
                    end
                    restart_pend <= 1'b0;
                    // Go straight back to ISSUE for a queued or coincident
                    // request: one word every three cycles when streaming.
                    if (play_audio && (pending || next_word)) begin
                        state          <= ISSUE;
                        flash_mem_read <= 1'b1;
                        pending        <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state          <= IDLE;
                    flash_mem_read <= 1'b0;
                    data_valid     <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_reader.sv
// ---------------------------------------------------------------------------
// tb_flash_reader
//
// Bench for flash_reader: an Avalon-MM flash slave model with configurable
// stall and response delay, a transaction-level reference model of the
// reader, directed scenarios with hand-computed expectations, and a long
// randomized run. Every cycle the DUT outputs are compared with the model.
// ---------------------------------------------------------------------------
module tb_flash_reader;

    localparam int ADDR_W = 23;
    localparam int MAXA   = 'h7FFFF;

    logic              clk = 1'b0;
    logic              rst, play, fwd, rs, nw;
    logic              wr, rdv;
    logic [31:0]       rdata;
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic [31:0]       data_out;
    logic              data_valid;
    logic              busy;

    flash_reader dut (
        .clk                     (clk),
        .reset                   (rst),
        .play_audio              (play),
        .forward                 (fwd),
        .restart                 (rs),
        .next_word               (nw),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_waitrequest   (wr),
        .flash_mem_readdata      (rdata),
        .flash_mem_readdatavalid (rdv),
        .data_out                (data_out),
        .data_valid              (data_valid),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // ---------------- flash slave ----------------
    int          wait_cfg  = 0;   // stall cycles per read, <0 = random 0..3
    int          delay_cfg = 1;   // readdatavalid delay after accept, <=0 = random 1..4
    bit          use_fixed = 0;
    logic [31:0] fixed_word = 32'h0;
    bit          in_req = 0;
    int          wait_left = 0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_word = 32'h0;
    int          n_acc = 0;

    // ---------------- reference model ----------------
    bit              m_busy, m_acc, m_del, m_pend, m_rpend;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]     m_dout;

    // ---------------- per-run statistics ----------------
    int          s_valid, s_first_valid, s_reads, s_busy, s_acc, s_read_start2, s_nstarts;
    logic [31:0] s_data;
    int          s_first_addr;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic slave_drive();
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                rdv   = 1'b1;
                rdata = rsp_word;
            end else begin
                rdv   = 1'b0;
                rdata = $urandom;
            end
        end else begin
            rdv   = 1'b0;
            rdata = $urandom;
        end
        if (flash_mem_read === 1'b1) begin
            if (!in_req) begin
                in_req    = 1;
                wait_left = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
            end
            if (wait_left > 0) begin
                wr = 1'b1;
                wait_left--;
            end else begin
                wr       = 1'b0;
                in_req   = 0;
                rsp_cnt  = (delay_cfg <= 0) ? int'($urandom_range(1, 4)) : delay_cfg;
                rsp_word = use_fixed ? fixed_word : $urandom;
                n_acc++;
            end
        end else begin
            in_req = 0;
            wr     = 1'($urandom_range(0, 1));
        end
    endtask

    // Where a playback pass starts and how one word moves the pointer,
    // expressed as modular arithmetic over the MAXA+1 word window.
    function automatic logic [ADDR_W-1:0] start_of(input logic f);
        return f ? '0 : ADDR_W'(MAXA);
    endfunction

    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] a, input logic f);
        int t;
        t = (int'(a) + (f ? 1 : MAXA)) % (MAXA + 1);
        return ADDR_W'(t);
    endfunction

    // Reader behaviour for the coming edge, from the inputs now applied.
    // m_busy: a request is being served; m_acc: the slave has taken the read;
    // m_del: the word is being handed over this cycle.
    task automatic model_step();
        if (rst) begin
            m_busy = 0; m_acc = 0; m_del = 0; m_pend = 0; m_rpend = 0;
            m_addr = '0; m_dout = 32'h0;
        end else if (!m_busy) begin
            if (rs) m_addr = start_of(fwd);
            if (play && (nw || m_pend)) begin
                m_busy = 1; m_acc = 0; m_pend = 0;
            end
        end else if (m_del) begin
            m_addr  = (rs || m_rpend) ? start_of(fwd) : advance(m_addr, fwd);
            m_rpend = 0;
            m_del   = 0;
            if (play && (nw || m_pend)) begin
                m_acc = 0; m_pend = 0;
            end else begin
                m_busy = 0;
            end
        end else begin
            if (rs) m_rpend = 1;
            if (nw) m_pend = 1;
            if (!m_acc) begin
                if (!wr) m_acc = 1;
            end else if (rdv) begin
                m_dout = rdata;
                m_del  = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("busy",   64'(busy),                 64'(m_busy));
        chk("read",   64'(flash_mem_read),       64'(m_busy && !m_acc && !m_del));
        chk("valid",  64'(data_valid),           64'(m_del));
        chk("addr",   64'(flash_mem_address),    64'(m_addr));
        chk("dout",   64'(data_out),             64'(m_dout));
        chk("byteen", 64'(flash_mem_byteenable), 64'(4'hF));
    endtask

    task automatic tick();
        slave_drive();
        model_step();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    // Runs ncyc cycles; next_word on the ticks flagged in nw_mask, restart on
    // tick rs_at, reset on tick rst_at. Observed cycle number is tick+1.
    task automatic run_txn(input int rs_at, input int rst_at, input logic [15:0] nw_mask,
                           input int ncyc);
        int acc0;
        bit prev_read;
        acc0 = n_acc;
        prev_read = 0;
        s_valid = 0; s_first_valid = -1; s_reads = 0; s_busy = 0;
        s_read_start2 = -1; s_nstarts = 0; s_data = 32'h0; s_first_addr = -1;
        for (int i = 0; i < ncyc; i++) begin
            nw  = (i < 16) && nw_mask[i[3:0]];
            rs  = (i == rs_at);
            rst = (i == rst_at);
            tick();
            if (data_valid === 1'b1) begin
                s_valid++;
                if (s_first_valid < 0) s_first_valid = i + 1;
                s_data = data_out;
            end
            if (busy === 1'b1) s_busy++;
            if (flash_mem_read === 1'b1) begin
                s_reads++;
                if (s_first_addr < 0) s_first_addr = int'(flash_mem_address);
                if (!prev_read) begin
                    s_nstarts++;
                    if (s_nstarts == 2) s_read_start2 = i + 1;
                end
            end
            prev_read = (flash_mem_read === 1'b1);
        end
        nw = 1'b0; rs = 1'b0; rst = 1'b0;
        s_acc = n_acc - acc0;
    endtask

    initial begin
        rst = 1'b1; play = 1'b0; fwd = 1'b1; rs = 1'b0; nw = 1'b0;
        wr = 1'b0; rdv = 1'b0; rdata = 32'h0;
        @(negedge clk);

        // Reset state
        tick();
        tick();
        chk("rst_busy",  64'(busy), 64'(0));
        chk("rst_read",  64'(flash_mem_read), 64'(0));
        chk("rst_valid", 64'(data_valid), 64'(0));
        chk("rst_addr",  64'(flash_mem_address), 64'(0));
        chk("rst_dout",  64'(data_out), 64'(0));
        rst = 1'b0;
        play = 1'b1;
        tick();

        // Minimum latency fetch from address 0
        use_fixed = 1; fixed_word = 32'h12345678; wait_cfg = 0; delay_cfg = 1;
        run_txn(-1, -1, 16'h0001, 6);
        chk("t1_valid_cycle", 64'(s_first_valid), 64'(3));
        chk("t1_data",        64'(s_data), 64'(32'h12345678));
        chk("t1_read_addr",   64'(s_first_addr), 64'(0));
        chk("t1_read_cycles", 64'(s_reads), 64'(1));
        chk("t1_next_addr",   64'(flash_mem_address), 64'(1));

        // Three waitrequest cycles in ISSUE
        use_fixed = 0; wait_cfg = 3;
        run_txn(-1, -1, 16'h0001, 9);
        chk("t2_valid_cycle", 64'(s_first_valid), 64'(6));
        chk("t2_read_cycles", 64'(s_reads), 64'(4));
        chk("t2_read_addr",   64'(s_first_addr), 64'(1));
        chk("t2_next_addr",   64'(flash_mem_address), 64'(2));
        wait_cfg = 0;

        // Wrap forward at MAX_ADDR, then backward at 0
        fwd = 1'b0; rs = 1'b1; tick(); rs = 1'b0;
        chk("t3_reload_max", 64'(flash_mem_address), 64'(MAXA));
        fwd = 1'b1;
        run_txn(-1, -1, 16'h0001, 6);
        chk("t3_fwd_read_addr", 64'(s_first_addr), 64'(MAXA));
        chk("t3_fwd_wrap",      64'(flash_mem_address), 64'(0));
        fwd = 1'b0;
        run_txn(-1, -1, 16'h0001, 6);
        chk("t3_bwd_read_addr", 64'(s_first_addr), 64'(0));
        chk("t3_bwd_wrap",      64'(flash_mem_address), 64'(MAXA));

        // Two requests during WAIT_DATA collapse into one extra read
        fwd = 1'b1; rs = 1'b1; tick(); rs = 1'b0;
        chk("t4_reload_zero", 64'(flash_mem_address), 64'(0));
        delay_cfg = 3;
        run_txn(-1, -1, 16'h000D, 20);
        chk("t4_valids",     64'(s_valid), 64'(2));
        chk("t4_accepts",    64'(s_acc), 64'(2));
        chk("t4_first_valid", 64'(s_first_valid), 64'(5));
        chk("t4_reissue",    64'(s_read_start2), 64'(6));
        chk("t4_end_addr",   64'(flash_mem_address), 64'(2));

        // Restart during WAIT_DATA at address 0x100
        delay_cfg = 1;
        for (int k = 0; k < 254; k++) run_txn(-1, -1, 16'h0001, 4);
        chk("t5_at_0x100", 64'(flash_mem_address), 64'(32'h100));
        use_fixed = 1; fixed_word = 32'hCAFE0100; delay_cfg = 2;
        run_txn(2, -1, 16'h0001, 8);
        chk("t5_valids",    64'(s_valid), 64'(1));
        chk("t5_read_addr", 64'(s_first_addr), 64'(32'h100));
        chk("t5_data",      64'(s_data), 64'(32'hCAFE0100));
        chk("t5_reload",    64'(flash_mem_address), 64'(0));

        // play_audio low: request in IDLE ignored and forgotten
        play = 1'b0;
        run_txn(-1, -1, 16'h0001, 5);
        chk("t6_no_accept", 64'(s_acc), 64'(0));
        chk("t6_no_busy",   64'(s_busy), 64'(0));
        play = 1'b1;
        run_txn(-1, -1, 16'h0000, 5);
        chk("t6_not_kept",  64'(s_acc), 64'(0));
        chk("t6_addr",      64'(flash_mem_address), 64'(0));

        // Reset in WAIT_DATA, late readdatavalid ignored
        fixed_word = 32'hA5A50001; delay_cfg = 1;
        run_txn(-1, -1, 16'h0001, 5);
        chk("t7_pre_dout", 64'(data_out), 64'(32'hA5A50001));
        chk("t7_pre_addr", 64'(flash_mem_address), 64'(1));
        delay_cfg = 4;
        run_txn(-1, 2, 16'h0001, 12);
        chk("t7_no_valid", 64'(s_valid), 64'(0));
        chk("t7_addr",     64'(flash_mem_address), 64'(0));
        chk("t7_dout",     64'(data_out), 64'(0));
        chk("t7_busy",     64'(busy), 64'(0));
        chk("t7_read",     64'(flash_mem_read), 64'(0));
        use_fixed = 0;

        // Randomized traffic checked cycle by cycle against the model
        wait_cfg = -1; delay_cfg = 0;
        for (int i = 0; i < 3000; i++) begin
            play = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) fwd = ~fwd;
            nw  = ($urandom_range(0, 3) == 0);
            rs  = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        nw = 1'b0; rs = 1'b0; rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
